stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N stream demultiplexer: the receiving-side counterpart of a stream mux. It accepts beats on a single valid/ready input and steers each beat to the output channel named by its in-band select field. A single holding register gives one cycle of latency and sustains full throughput. Beats with an out-of-range select are consumed, discarded and counted. The block sits where a shared stream fans out to per-consumer channels.

## Interface
- WIDTH, 8, data width in bits (1..64).
- N_OUT, 4, number of output channels (2..16). SEL_W is fixed at 4 bits regardless of N_OUT.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_sel  input  4  destination channel index; values >= N_OUT are invalid.
- out_valid  output  N_OUT  one-hot (or zero) valid, bit k for channel k.
- out_ready  input  N_OUT  per-channel ready.
- out_data  output  WIDTH  shared payload bus, meaningful for the channel whose out_valid bit is high.
- drop_pulse  output  1  one-cycle pulse marking that an invalid-select beat was discarded.
- drop_count  output  8  saturating count of discarded beats.

## Operation
- Handshake: a transfer occurs on a cycle where valid and ready are both 1 at the rising clk edge. This rule applies to the input and to each output channel.
- The block has two states.
- EMPTY state: in_ready=1, out_valid=0.
  - On an input handshake with in_sel<N_OUT: load data_q<=in_data and sel_q<=in_sel, then go to FULL.
  - On an input handshake with in_sel>=N_OUT: discard the beat, assert drop_pulse next cycle, increment drop_count, and stay in EMPTY.
- FULL state: out_valid = one-hot(sel_q), out_data = data_q, in_ready = out_ready[sel_q] (combinational path, allowed).
  - out_ready[k] for k != sel_q is ignored.
  - Drain with a simultaneous valid input: load the new beat and stay in FULL, or, if its select is invalid, drop it and go to EMPTY.
  - Drain with no input: go to EMPTY.
  - No drain: hold everything. in_ready=0, so no input is accepted, including invalid-select beats.
- Output stability: while out_valid[k]=1 and out_ready[k]=0, out_valid and out_data must not change.
- Ordering: beats leave in acceptance order. The block never duplicates a beat and never loses a valid-select beat.
- drop_count: +1 per discarded beat, saturating at 255 (no wrap). drop_pulse is registered and goes high exactly one cycle after each drop handshake. Back-to-back drops hold it high on consecutive cycles.

## Timing
- Reset (rst_n low, asynchronous assertion): state=EMPTY, out_valid=0, out_data=0, drop_pulse=0, drop_count=0, in_ready=0.
  - in_ready goes to 1 from the first cycle after rst_n deasserts.
  - Reset in mid-operation discards any held beat.
- Latency: a beat accepted at edge t appears on out_valid/out_data after edge t. It is visible in cycle t+1.
- Throughput: 1 beat/cycle when the target consumer holds out_ready high, including when consecutive beats switch channels.
- drop_count updates on the same edge at which drop_pulse rises.
- The only combinational paths are out_ready -> in_ready and sel_q -> out_valid; everything else is registered.

## Test plan
- Reset check: hold rst_n=0, then release. Require out_valid=0, drop_count=0, drop_pulse=0, and in_ready=1 one cycle after release.
- Routing with all out_ready=1: send sel sequence 0,1,2,3 with data 0x10,0x11,0x12,0x13 on consecutive cycles. Require out_valid=0001,0010,0100,1000 with matching data, one beat per cycle, first beat one cycle after the first input handshake.
- Backpressure: send sel=2, data=0xA5 with out_ready[2]=0 for 5 cycles and out_ready[0,1,3]=1. Require out_valid=0100 and out_data=0xA5 stable, in_ready=0 throughout. On raising out_ready[2], the transfer completes and in_ready=1 in the same cycle.
- Invalid select: send sel=7 with N_OUT=4. Require in_ready=1, the beat is consumed, out_valid stays 0, drop_pulse=1 for exactly one cycle, drop_count=1.
- Saturation: send 300 invalid-select beats. Require drop_count=255 and no wrap; then a valid beat with sel=1, data=0x3C is delivered normally.
- Mid-transfer reset: hold a beat in FULL (out_ready=0) and pulse rst_n low asynchronously between edges. Require out_valid=0 immediately and no stale beat after reset is released.

Source files
------------

// File: rtl/stream_demux_if.sv
// Bundle of the stream_demux input stream, per-channel output streams and drop status.
// The slave modport is the demux side; master is the producer/consumer side.
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_sel;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic [WIDTH-1:0] out_data;
    logic             drop_pulse;
    logic [7:0]       drop_count;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_pulse, drop_count
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_pulse, drop_count
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: one holding register steers each beat to the
// channel named by its select field; out-of-range selects are dropped and counted.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux_if.slave bus,
    output logic [0:0]    state_dbg
);
    // Valid/ready: a beat transfers on any rising clk edge where valid and ready are both 1,
    // on the input and independently on every output channel; a valid beat is never withdrawn.

    localparam int SEL_W = 4;
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
    localparam logic [SEL_W:0] N_OUT_L = 5'(N_OUT);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic             live_q;
    logic             drop_pulse_q;
    logic [7:0]       drop_count_q;

    logic sel_ready;
    logic in_ready_c;
    logic in_fire;
    logic in_ok;
    logic drain;
    logic load;
    logic drop;

    // Only the addressed channel's ready matters; the others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_q == SEL_W'(k)) sel_ready = bus.out_ready[k];
        end
    end

    always_comb begin
        bus.out_valid = '0;
        if (state_q == ST_FULL) begin
            for (int k = 0; k < N_OUT; k++) begin
                bus.out_valid[k] = (sel_q == SEL_W'(k));
            end
        end
    end

    // live_q keeps in_ready low during reset and for the cycle it is released.
    assign in_ready_c = (state_q == ST_FULL) ? sel_ready : live_q;
    assign in_fire    = bus.in_valid & in_ready_c;
    assign in_ok      = ({1'b0, bus.in_sel} < N_OUT_L);
    assign drain      = (state_q == ST_FULL) & sel_ready;
    assign load       = in_fire & in_ok;
    assign drop       = in_fire & ~in_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (drain) state_d = load ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (load) begin
                data_q <= bus.in_data;
                sel_q  <= bus.in_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop;
            if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_data   = data_q;
    assign bus.drop_pulse = drop_pulse_q;
    assign bus.drop_count = drop_count_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (WIDTH=8, N_OUT=4).
// Inputs change on the falling edge; outputs are checked just after it.
module tb_stream_demux;
    logic       clk;
    logic       rst_n;
    logic [0:0] state_dbg;
    int         errors;
    int         checks;

    stream_demux_if #(.WIDTH(8), .N_OUT(4)) bus ();

    stream_demux #(.WIDTH(8), .N_OUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 8'h00);
        bus.out_ready = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse got=%b exp=0", bus.drop_pulse); end
        checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", bus.drop_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got=%b exp=0", bus.in_ready); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL release_state got=%b exp=0", state_dbg); end
    endtask

    task automatic test_routing;
        logic [3:0] exp_v [4];
        exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bus.out_ready = 4'b1111;
        drive(1'b1, 4'd0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.out_valid !== exp_v[i]) begin errors++; $display("FAIL route_valid[%0d] got=%b exp=%b", i, bus.out_valid, exp_v[i]); end
            checks++; if (bus.out_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL route_data[%0d] got=%h exp=%h", i, bus.out_data, 8'(8'h10 + i)); end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
            if (i < 3) drive(1'b1, 4'(i + 1), 8'(8'h11 + i));
            else drive(1'b0, 4'd0, 8'h00);
        end
        step();
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL route_idle got=%b exp=0000", bus.out_valid); end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 4'b1011;
        drive(1'b1, 4'd2, 8'hA5);
        step();
        drive(1'b1, 4'd0, 8'h55);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 4'b0100) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=0100", i, bus.out_valid); end
            checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=a5", i, bus.out_data); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
            if (i < 4) step();
        end
        checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL bp_state got=%b exp=1", state_dbg); end
        bus.out_ready = 4'b1111;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 4'b0001) begin errors++; $display("FAIL bp_next_valid got=%b exp=0001", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h55) begin errors++; $display("FAIL bp_next_data got=%h exp=55", bus.out_data); end
        drive(1'b0, 4'd0, 8'h00);
        step();
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL bp_idle got=%b exp=0000", bus.out_valid); end
    endtask

    task automatic test_invalid;
        bus.out_ready = 4'b1111;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL inv_in_ready got=%b exp=1", bus.in_ready); end
        drive(1'b1, 4'd7, 8'hEE);
        step();
        drive(1'b0, 4'd0, 8'h00);
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL inv_valid got=%b exp=0000", bus.out_valid); end
        checks++; if (bus.drop_pulse !== 1'b1) begin errors++; $display("FAIL inv_pulse got=%b exp=1", bus.drop_pulse); end
        checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL inv_count got=%0d exp=1", bus.drop_count); end
        step();
        checks++; if (bus.drop_pulse !== 1'b0) begin errors++; $display("FAIL inv_pulse_end got=%b exp=0", bus.drop_pulse); end
        checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL inv_count_hold got=%0d exp=1", bus.drop_count); end
        // Drop while FULL and draining: held beat leaves, block returns to EMPTY.
        drive(1'b1, 4'd1, 8'h22);
        step();
        drive(1'b1, 4'd9, 8'h99);
        checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL inv_full_valid got=%b exp=0010", bus.out_valid); end
        step();
        drive(1'b1, 4'd15, 8'h01);
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL inv_full_drop_valid got=%b exp=0000", bus.out_valid); end
        checks++; if (bus.drop_count !== 8'd2) begin errors++; $display("FAIL inv_full_count got=%0d exp=2", bus.drop_count); end
        step();
        drive(1'b1, 4'd15, 8'h02);
        step();
        drive(1'b0, 4'd0, 8'h00);
        checks++; if (bus.drop_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pulse got=%b exp=1", bus.drop_pulse); end
        checks++; if (bus.drop_count !== 8'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", bus.drop_count); end
        step();
        checks++; if (bus.drop_pulse !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got=%b exp=0", bus.drop_pulse); end
    endtask

    task automatic test_saturation;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'(4 + (i % 12)), 8'(i));
            step();
        end
        drive(1'b1, 4'd1, 8'h3C);
        checks++; if (bus.drop_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", bus.drop_count); end
        checks++; if (bus.drop_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse got=%b exp=1", bus.drop_pulse); end
        step();
        drive(1'b0, 4'd0, 8'h00);
        checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL sat_valid got=%b exp=0010", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL sat_data got=%h exp=3c", bus.out_data); end
        checks++; if (bus.drop_pulse !== 1'b0) begin errors++; $display("FAIL sat_pulse_end got=%b exp=0", bus.drop_pulse); end
        checks++; if (bus.drop_count !== 8'd255) begin errors++; $display("FAIL sat_count_hold got=%0d exp=255", bus.drop_count); end
        step();
    endtask

    task automatic test_mid_reset;
        bus.out_ready = 4'b0000;
        drive(1'b1, 4'd3, 8'h77);
        step();
        drive(1'b0, 4'd0, 8'h00);
        checks++; if (bus.out_valid !== 4'b1000) begin errors++; $display("FAIL mr_held got=%b exp=1000", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mr_async_valid got=%b exp=0000", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mr_async_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL mr_async_count got=%0d exp=0", bus.drop_count); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mr_stale[%0d] got=%b exp=0000", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 4'd0;
        bus.in_data = 8'h00;
        bus.out_ready = 4'b0000;
        test_reset();
        test_routing();
        test_backpressure();
        test_invalid();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
